// File: rtl/mat_control.sv
// mat_control: instruction sequencer for the matrix tile.
//
// Fetches one 128-bit instruction per cycle from a combinational instruction
// memory and moves WIDTH-element vectors between data memory, the vector
// cache and the systolic matrix unit. Vector elements are IEEE-754 single
// precision bit patterns (element i at bits [32*i +: 32]).
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   done                     high once HALT has executed
//   inst_mem_addr/_value     PC (word index) and the instruction at PC
//   data_mem_addr/_value     vector index and the vector at that index
//   unit_set_weight/_row     load unit_data_in as weight row _row this edge
//   unit_data_in/_out        unit operand; result valid one cycle later
//   cache_read_*             read op (0 none, 1 vec), slots and param
//   cache_write_*            write op (0 none, 1 vec, 2 elem), slots, params
//   cache_data_in/_out       cache write data and combinational read data
module mat_control #(
  parameter int unsigned WIDTH               = 16,
  parameter int unsigned CACHE_SIZE          = 8,
  parameter int unsigned INST_MEM_ADDR_SIZE  = 32,
  parameter int unsigned DATA_MEM_ADDR_SIZE  = 32,
  parameter int unsigned INST_MEM_WIDTH_SIZE = 128,
  parameter int unsigned WIDTH_ADDR_SIZE     = $clog2(WIDTH),
  parameter int unsigned CACHE_ADDR_SIZE     = $clog2(CACHE_SIZE)
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic                              done,
  output logic [INST_MEM_ADDR_SIZE-1:0]     inst_mem_addr,
  input  logic [INST_MEM_WIDTH_SIZE-1:0]    inst_mem_value,
  output logic [DATA_MEM_ADDR_SIZE-1:0]     data_mem_addr,
  input  logic [WIDTH-1:0][31:0]            data_mem_value,
  output logic                              unit_set_weight,
  output logic [WIDTH_ADDR_SIZE-1:0]        unit_set_weight_row,
  output logic [WIDTH-1:0][31:0]            unit_data_in,
  input  logic [WIDTH-1:0][31:0]            unit_data_out,
  output logic                              cache_read_op,
  output logic [CACHE_ADDR_SIZE-1:0]        cache_read_addr1,
  output logic [CACHE_ADDR_SIZE-1:0]        cache_read_addr2,
  output logic [WIDTH_ADDR_SIZE-1:0]        cache_read_param,
  output logic [1:0]                        cache_write_op,
  output logic [CACHE_ADDR_SIZE-1:0]        cache_write_addr1,
  output logic [CACHE_ADDR_SIZE-1:0]        cache_write_addr2,
  output logic [WIDTH_ADDR_SIZE-1:0]        cache_write_param1,
  output logic [WIDTH_ADDR_SIZE-1:0]        cache_write_param2,
  output logic [WIDTH-1:0][31:0]            cache_data_in,
  input  logic [WIDTH-1:0][31:0]            cache_data_out
);

  localparam logic       MdroNone = 1'b0;
  localparam logic       MdroVec  = 1'b1;
  localparam logic [1:0] MdwoNone = 2'd0;
  localparam logic [1:0] MdwoVec  = 2'd1;
  localparam logic [1:0] MdwoElem = 2'd2;

  localparam logic [7:0] OpHalt = 8'h01;
  localparam logic [7:0] OpLoad = 8'h10;
  localparam logic [7:0] OpSetw = 8'h20;
  localparam logic [7:0] OpMul  = 8'h30;
  localparam logic [7:0] OpMove = 8'h40;

  localparam logic [INST_MEM_ADDR_SIZE-1:0] PcOne = {{(INST_MEM_ADDR_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StRun, StWait, StHalted} state_e;

  state_e                        state_q, state_d;
  logic [INST_MEM_ADDR_SIZE-1:0] pc_q, pc_d;

  // Instruction fields; only the low bits of each register/param byte matter.
  logic [7:0]                    opcode;
  logic [CACHE_ADDR_SIZE-1:0]    r1, r2;
  logic [WIDTH_ADDR_SIZE-1:0]    p1, p2;
  logic [DATA_MEM_ADDR_SIZE-1:0] imm;

  assign opcode = inst_mem_value[127:120];
  assign r1     = inst_mem_value[112 +: CACHE_ADDR_SIZE];
  assign r2     = inst_mem_value[104 +: CACHE_ADDR_SIZE];
  assign p1     = inst_mem_value[96 +: WIDTH_ADDR_SIZE];
  assign p2     = inst_mem_value[88 +: WIDTH_ADDR_SIZE];
  assign imm    = inst_mem_value[0 +: DATA_MEM_ADDR_SIZE];

  logic unused_inst;
  assign unused_inst = ^inst_mem_value;

  assign inst_mem_addr = pc_q;
  assign done          = (state_q == StHalted);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    pc_d                = pc_q;
    data_mem_addr       = '0;
    unit_set_weight     = 1'b0;
    unit_set_weight_row = '0;
    unit_data_in        = '0;
    cache_read_op       = MdroNone;
    cache_read_addr1    = '0;
    cache_read_addr2    = '0;
    cache_read_param    = '0;
    cache_write_op      = MdwoNone;
    cache_write_addr1   = '0;
    cache_write_addr2   = '0;
    cache_write_param1  = '0;
    cache_write_param2  = '0;
    cache_data_in       = '0;

    // Nothing executes while reset is held, so a pending MUL write-back is dropped.
    if (!reset) begin
      case (state_q)
        StRun: begin
          pc_d = pc_q + PcOne;
          case (opcode)
            OpHalt: begin
              state_d = StHalted;
              pc_d    = pc_q;
            end
            OpLoad: begin
              data_mem_addr     = imm;
              cache_write_op    = MdwoVec;
              cache_write_addr1 = r1;
              cache_data_in     = data_mem_value;
            end
            OpSetw: begin
              cache_read_op       = MdroVec;
              cache_read_addr1    = r1;
              unit_data_in        = cache_data_out;
              unit_set_weight     = 1'b1;
              unit_set_weight_row = p1;
            end
            OpMul: begin
              cache_read_op    = MdroVec;
              cache_read_addr1 = r1;
              unit_data_in     = cache_data_out;
              state_d          = StWait;
              pc_d             = pc_q;
            end
            OpMove: begin
              // slot[r2][p2] <= slot[r1][p1]
              cache_read_op      = MdroVec;
              cache_read_addr1   = r1;
              cache_write_op     = MdwoElem;
              cache_write_addr1  = r2;
              cache_write_param1 = p2;
              cache_write_param2 = p1;
              cache_data_in      = cache_data_out;
            end
            default: ;
          endcase
        end
        StWait: begin
          // PC was held, so inst_mem_value is still the MUL and r2 is its target.
          cache_write_op    = MdwoVec;
          cache_write_addr1 = r2;
          cache_data_in     = unit_data_out;
          pc_d              = pc_q + PcOne;
          state_d           = StRun;
        end
        StHalted: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_control.sv
module tb_mat_control;

  localparam int W  = 16;
  localparam int CS = 16;

  typedef logic [W-1:0][31:0] vec_t;
  typedef struct {
    logic [1:0] op;
    logic [3:0] a1;
    logic [3:0] pa1;
    logic [3:0] pa2;
    vec_t       data;
  } wr_t;
  typedef struct {
    logic [3:0] row;
    vec_t       data;
  } sw_t;

  logic         clock;
  logic         reset;
  logic         done;
  logic [31:0]  inst_mem_addr;
  logic [127:0] inst_mem_value;
  logic [31:0]  data_mem_addr;
  vec_t         data_mem_value;
  logic         unit_set_weight;
  logic [3:0]   unit_set_weight_row;
  vec_t         unit_data_in;
  vec_t         unit_data_out;
  logic         cache_read_op;
  logic [3:0]   cache_read_addr1;
  logic [3:0]   cache_read_addr2;
  logic [3:0]   cache_read_param;
  logic [1:0]   cache_write_op;
  logic [3:0]   cache_write_addr1;
  logic [3:0]   cache_write_addr2;
  logic [3:0]   cache_write_param1;
  logic [3:0]   cache_write_param2;
  vec_t         cache_data_in;
  vec_t         cache_data_out;

  int checks;
  int errors;

  wr_t exp_wr[$];
  sw_t exp_sw[$];

  logic [127:0] imem [64];
  vec_t         dmem [32];
  vec_t         cache [CS];
  vec_t         wts [W];

  mat_control #(
    .WIDTH      (W),
    .CACHE_SIZE (CS)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .done                (done),
    .inst_mem_addr       (inst_mem_addr),
    .inst_mem_value      (inst_mem_value),
    .data_mem_addr       (data_mem_addr),
    .data_mem_value      (data_mem_value),
    .unit_set_weight     (unit_set_weight),
    .unit_set_weight_row (unit_set_weight_row),
    .unit_data_in        (unit_data_in),
    .unit_data_out       (unit_data_out),
    .cache_read_op       (cache_read_op),
    .cache_read_addr1    (cache_read_addr1),
    .cache_read_addr2    (cache_read_addr2),
    .cache_read_param    (cache_read_param),
    .cache_write_op      (cache_write_op),
    .cache_write_addr1   (cache_write_addr1),
    .cache_write_addr2   (cache_write_addr2),
    .cache_write_param1  (cache_write_param1),
    .cache_write_param2  (cache_write_param2),
    .cache_data_in       (cache_data_in),
    .cache_data_out      (cache_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Float helpers for small non-negative integers.
  function automatic logic [31:0] i2f(input int n);
    int e;
    logic [31:0] m;
    if (n <= 0) return 32'h0;
    e = 0;
    for (int k = 0; k < 24; k++) if (((n >> k) & 1) != 0) e = k;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] b);
    int e;
    logic [23:0] m;
    e = int'(b[30:23]) - 127;
    if (b[30:0] == 31'h0 || e < 0 || e > 23) return 0;
    m = {1'b1, b[22:0]} >> (23 - e);
    return int'(m);
  endfunction

  function automatic vec_t vseq(input int s);
    vec_t r;
    for (int i = 0; i < W; i++) r[i] = i2f(s + i);
    return r;
  endfunction

  function automatic logic [127:0] mk(input logic [7:0] op, input logic [7:0] r1,
                                      input logic [7:0] r2, input logic [7:0] p1,
                                      input logic [7:0] p2, input logic [31:0] imm);
    return {op, r1, r2, p1, p2, 56'h0, imm};
  endfunction

  // y[j] = sum_i x[i] * W[i][j]
  function automatic vec_t matvec(input vec_t x);
    vec_t r;
    int acc;
    for (int j = 0; j < W; j++) begin
      acc = 0;
      for (int i = 0; i < W; i++) acc += f2i(x[i]) * f2i(wts[i][j]);
      r[j] = i2f(acc);
    end
    return r;
  endfunction

  // Memory, cache and unit models.
  always_comb inst_mem_value = (inst_mem_addr < 32'd64) ? imem[inst_mem_addr[5:0]] : '0;
  always_comb data_mem_value = (data_mem_addr < 32'd32) ? dmem[data_mem_addr[4:0]] : '0;
  always_comb cache_data_out = cache_read_op ? cache[cache_read_addr1] : '0;

  always @(posedge clock) begin
    if (cache_write_op == 2'd1) cache[cache_write_addr1] <= cache_data_in;
    else if (cache_write_op == 2'd2)
      cache[cache_write_addr1][cache_write_param1] <= cache_data_in[cache_write_param2];
    if (unit_set_weight) wts[unit_set_weight_row] <= unit_data_in;
    unit_data_out <= matvec(unit_data_in);
  end

  // Monitor: compares every DUT transaction against the scoreboard queues.
  always @(negedge clock) begin
    wr_t e;
    sw_t s;
    checks++;
    if (cache_read_addr2 != 0 || cache_write_addr2 != 0 || cache_read_param != 0) begin
      errors++;
      $display("FAIL tied_zero: got ra2=%0d wa2=%0d rp=%0d, want 0", cache_read_addr2,
               cache_write_addr2, cache_read_param);
    end
    if (cache_write_op != 2'd0) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got op=%0d a1=%0d at t=%0t, want none",
                 cache_write_op, cache_write_addr1, $time);
      end else begin
        e = exp_wr.pop_front();
        if (cache_write_op != e.op || cache_write_addr1 != e.a1 ||
            cache_write_param1 != e.pa1 || cache_write_param2 != e.pa2 ||
            cache_data_in != e.data) begin
          errors++;
          $display("FAIL cache_write: got op=%0d a1=%0d p1=%0d p2=%0d d=%h, want op=%0d a1=%0d p1=%0d p2=%0d d=%h",
                   cache_write_op, cache_write_addr1, cache_write_param1, cache_write_param2,
                   cache_data_in, e.op, e.a1, e.pa1, e.pa2, e.data);
        end
      end
    end
    if (unit_set_weight) begin
      checks++;
      if (exp_sw.size() == 0) begin
        errors++;
        $display("FAIL unexpected_setw: got row=%0d, want none", unit_set_weight_row);
      end else begin
        s = exp_sw.pop_front();
        if (unit_set_weight_row != s.row || unit_data_in != s.data) begin
          errors++;
          $display("FAIL set_weight: got row=%0d d=%h, want row=%0d d=%h",
                   unit_set_weight_row, unit_data_in, s.row, s.data);
        end
      end
    end
    if (!unit_set_weight && cache_write_op == 2'd0 && !cache_read_op) begin
      checks++;
      if (cache_read_addr1 != 0 || cache_write_addr1 != 0 || cache_write_param1 != 0 ||
          cache_write_param2 != 0 || data_mem_addr != 0 || unit_set_weight_row != 0 ||
          unit_data_in != '0 || cache_data_in != '0) begin
        errors++;
        $display("FAIL idle_defaults: got nonzero control at t=%0t, want all 0", $time);
      end
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [1:0] op, input int a1, input int pa1, input int pa2,
                         input vec_t d);
    wr_t e;
    e.op = op; e.a1 = 4'(a1); e.pa1 = 4'(pa1); e.pa2 = 4'(pa2); e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = '0;
  endtask

  // One reset edge, then release; PC must read 0 and done low.
  task automatic apply_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("done_in_reset", done, 0);
    chk("pc_after_reset", inst_mem_addr, 0);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clock);
      #1 n++;
    end
    chk({name, "_cycles"}, n, exp_cycles);
  endtask

  task automatic check_drained(input string name);
    chk({name, "_wr_q_empty"}, exp_wr.size(), 0);
    chk({name, "_sw_q_empty"}, exp_sw.size(), 0);
  endtask

  initial begin
    vec_t v;
    int n;
    reset  = 1'b1;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) dmem[i] = '0;
    dmem[3] = vseq(1);
    dmem[5] = vseq(101);
    for (int i = 0; i < W; i++) begin
      v = '0;
      v[i] = i2f(1);
      dmem[16 + i] = v;
    end

    // HALT at address 0.
    clear_prog();
    imem[0] = mk(8'h01, 0, 0, 0, 0, 0);
    apply_reset();
    wait_done("halt", 1);
    chk("halt_pc", inst_mem_addr, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("halt_pc_frozen", inst_mem_addr, 0);
    chk("halt_done_held", done, 1);
    check_drained("halt");

    // LOAD r1=2 imm=3; HALT.
    clear_prog();
    imem[0] = mk(8'h10, 2, 0, 0, 0, 3);
    imem[1] = mk(8'h01, 0, 0, 0, 0, 0);
    push_wr(2'd1, 2, 0, 0, dmem[3]);
    apply_reset();
    wait_done("load", 2);
    chk("load_pc", inst_mem_addr, 1);
    chk("load_slot2", cache[2], dmem[3]);
    check_drained("load");

    // Identity weights, then MUL of x={1..16} gives x back.
    clear_prog();
    for (int i = 0; i < W; i++) begin
      imem[i]      = mk(8'h10, 8'(i), 0, 0, 0, 32'(16 + i));
      imem[16 + i] = mk(8'h20, 8'(i), 0, 8'(i), 0, 0);
      push_wr(2'd1, i, 0, 0, dmem[16 + i]);
    end
    for (int i = 0; i < W; i++) begin
      sw_t s;
      s.row = 4'(i); s.data = dmem[16 + i];
      exp_sw.push_back(s);
    end
    imem[32] = mk(8'h10, 1, 0, 0, 0, 3);
    imem[33] = mk(8'h30, 1, 3, 0, 0, 0);
    imem[34] = mk(8'h01, 0, 0, 0, 0, 0);
    push_wr(2'd1, 1, 0, 0, dmem[3]);
    push_wr(2'd1, 3, 0, 0, dmem[3]);
    apply_reset();
    wait_done("mul", 36);
    chk("mul_pc", inst_mem_addr, 34);
    chk("mul_slot3", cache[3], dmem[3]);
    check_drained("mul");

    // MOVE: slot5[0] <= slot1[4] (5.0), slot5[9] <= slot1[7] (8.0).
    clear_prog();
    imem[0] = mk(8'h10, 5, 0, 0, 0, 5);
    imem[1] = mk(8'h10, 1, 0, 0, 0, 3);
    imem[2] = mk(8'h40, 1, 5, 4, 0, 0);
    imem[3] = mk(8'h40, 1, 5, 7, 9, 0);
    imem[4] = mk(8'h01, 0, 0, 0, 0, 0);
    push_wr(2'd1, 5, 0, 0, dmem[5]);
    push_wr(2'd1, 1, 0, 0, dmem[3]);
    push_wr(2'd2, 5, 0, 4, dmem[3]);
    push_wr(2'd2, 5, 9, 7, dmem[3]);
    apply_reset();
    wait_done("move", 5);
    chk("move_pc", inst_mem_addr, 4);
    v = dmem[5];
    v[0] = i2f(5);
    v[9] = i2f(8);
    chk("move_slot5", cache[5], v);
    check_drained("move");

    // Unknown opcode behaves as NOP.
    clear_prog();
    imem[0] = mk(8'h7F, 3, 4, 5, 6, 7);
    imem[1] = mk(8'h01, 0, 0, 0, 0, 0);
    apply_reset();
    wait_done("nop", 2);
    chk("nop_pc", inst_mem_addr, 1);
    check_drained("nop");

    // Reset while MUL is in its write-back cycle: write-back is dropped.
    clear_prog();
    imem[0] = mk(8'h10, 6, 0, 0, 0, 5);
    imem[1] = mk(8'h10, 1, 0, 0, 0, 3);
    imem[2] = mk(8'h30, 1, 6, 0, 0, 0);
    imem[3] = mk(8'h01, 0, 0, 0, 0, 0);
    push_wr(2'd1, 6, 0, 0, dmem[5]);
    push_wr(2'd1, 1, 0, 0, dmem[3]);
    apply_reset();
    n = 0;
    while (inst_mem_addr != 32'd2 && n < 50) begin
      @(posedge clock);
      #1 n++;
    end
    chk("rst_reach_mul", inst_mem_addr, 2);
    @(posedge clock);
    #1;
    chk("rst_mul_pc_held", inst_mem_addr, 2);
    reset = 1'b1;
    imem[0] = mk(8'h01, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    chk("rst_pc_zero", inst_mem_addr, 0);
    chk("rst_done_low", done, 0);
    reset = 1'b0;
    wait_done("rst_restart", 1);
    chk("rst_restart_pc", inst_mem_addr, 0);
    chk("rst_slot6", cache[6], dmem[5]);
    check_drained("rst");

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
